spatz_vrf_arbiter: RTL and testbench
====================================

SPATZ_VRF_ARBITER -- requirements
Module: spatz_vrf_arbiter

Interface
REQ-001 SHALL have parameter NrReadPorts, default 5: number of read requesters.
REQ-002 SHALL have parameter NrWritePorts, default 3: number of write requesters.
REQ-003 SHALL have parameter NrBanks, default 4, power of two: number of VRF banks.
REQ-004 SHALL have parameter NrBankRdPorts, default 3: read ports per bank.
REQ-005 SHALL have parameter RdPortMap, default {0,1,2,1,2}: bank read port index per read requester.
REQ-006 SHALL have parameter StarveLimit, default 4, range 1..15: consecutive blocked cycles before promotion.
REQ-007 SHALL have one clock and an asynchronous, active-high reset: clk_i input 1 (clock), then rst_i input 1 (reset).
REQ-008 SHALL have write-side ports: waddr_i input NrWritePorts x vreg_addr_t; wdata_i input NrWritePorts x vreg_data_t; we_i input NrWritePorts (request); wbe_i input NrWritePorts x vreg_be_t; wgnt_o output NrWritePorts (grant).
REQ-009 SHALL have read-side ports: raddr_i input NrReadPorts x vreg_addr_t; re_i input NrReadPorts (request); rgnt_o output NrReadPorts (grant); rdata_o output NrReadPorts x vreg_data_t; rvalid_o output NrReadPorts.
REQ-010 SHALL have write bank-side ports: bank_waddr_o, bank_wdata_o, bank_we_o and bank_wbe_o, all outputs, NrBanks wide.
REQ-011 SHALL have read bank-side ports: bank_raddr_o output NrBanks x NrBankRdPorts; bank_re_o output NrBanks x NrBankRdPorts; bank_rdata_i input NrBanks x NrBankRdPorts x vreg_data_t.

Function
REQ-012 SHALL arbitrate each bank write port among write requesters with we_i set and a matching waddr_i.bank field; exactly one grant per bank per cycle.
REQ-013 SHALL arbitrate each bank read port p among read requesters r with RdPortMap[r]==p, re_i set and a matching raddr_i.bank field.
REQ-014 SHALL apply the following priority: promoted requesters beat non-promoted ones; within a class, the lowest index wins.
REQ-015 SHALL make grants combinational in the request cycle; bank_*_o SHALL carry the granted requester's vreg/data/be fields; ungranted bank ports SHALL be driven with zero outputs.
REQ-016 SHALL require a requester to hold its request stable until granted; a request dropped without a grant SHALL be legal.
REQ-017 SHALL register the routing (bank, port) for each read grant, because the bank returns data one cycle after bank_re_o.
REQ-018 SHALL assert rvalid_o[r] exactly one cycle after rgnt_o[r], with rdata_o[r]=bank_rdata_i[bank_q][port_q]; otherwise rdata_o SHALL be 0.
REQ-019 SHALL allow back-to-back grants every cycle per requester, giving a throughput of 1 per cycle.
REQ-020 SHALL not forward data for a same-cycle write and read of the same vreg: the read returns the pre-write content.
REQ-021 SHALL keep a per-requester starve counter: +1 per cycle while requesting and not granted, saturating at StarveLimit; cleared on grant or when the request drops.
REQ-022 SHALL treat a requester as promoted while its counter==StarveLimit.

Reset
REQ-023 SHALL, when rst_i is asserted, immediately clear all starve counters, registered routing and rvalid_o; rdata_o SHALL be 0.
REQ-024 SHALL remain combinational in grant outputs during reset, but SHALL not assert rvalid_o in the first cycle after release.

Configuration
REQ-025 SHALL, with SPATZ_VRF_STARVE_EN defined, implement the starve counters and promotion of REQ-021/022.
REQ-026 SHALL, without SPATZ_VRF_STARVE_EN, omit the counters and use strict fixed priority (lowest index wins); all else is unchanged.

Structure
REQ-027 SHALL place vreg_addr_t (bank/vreg fields sized by NrBanks), vreg_data_t, vreg_be_t and the default StarveLimit in spatz_pkg.
REQ-028 SHALL use one sub-module, spatz_vrf_prio_arb: a combinational fixed-priority arbiter taking a request vector and a promote vector, and producing a one-hot grant; it is instantiated per bank write port and per bank read port.
REQ-029 SHALL raise an elaboration error if any RdPortMap entry is >= NrBankRdPorts, or if NrBanks is not a power of two.

Verification
REQ-030 SHALL cover a read conflict: read requesters 1 and 3 on bank 2, port 1 -> rgnt_o=0b00010; rvalid_o[1] next cycle with bank_rdata_i[2][1].
REQ-031 SHALL cover a write conflict: writers 0 and 2 on bank 0 while writer 1 targets bank 3 -> wgnt_o=0b011; bank_we_o=0b1001.
REQ-032 SHALL cover starvation with STARVE_EN and StarveLimit=4: requesters 1 and 3 continuously on bank 0, port 1 -> requester 3 granted in cycle 5, after which the counter clears.
REQ-033 SHALL cover the build without STARVE_EN under the same stimulus as REQ-032 -> requester 3 is never granted within 20 cycles.
REQ-034 SHALL cover reset mid-operation: rst_i asserted in the cycle after a read grant -> rvalid_o=0 immediately; no rvalid_o after release.
REQ-035 SHALL cover streaming: requester 0 reads 8 consecutive cycles, uncontended -> 8 grants and 8 rvalid_o pulses, each offset by one cycle.

Source files
------------

// File: rtl/spatz_pkg.sv
// Shared VRF address/data types and arbiter defaults for the Spatz VRF slice.
package spatz_pkg;

  localparam int unsigned VrfNrBanks         = 4;
  localparam int unsigned NrVregs            = 32;
  localparam int unsigned BankWidth          = $clog2(VrfNrBanks);
  localparam int unsigned VregWidth          = $clog2(NrVregs / VrfNrBanks);
  localparam int unsigned DataWidth          = 32;
  localparam int unsigned DefaultStarveLimit = 4;
  localparam int unsigned StarveCntWidth     = 4;

  typedef logic [VregWidth-1:0] vreg_idx_t;

  // Bank select sits in the low bits so consecutive vregs interleave across banks.
  typedef struct packed {
    vreg_idx_t            vreg;
    logic [BankWidth-1:0] bank;
  } vreg_addr_t;

  typedef logic [DataWidth-1:0]   vreg_data_t;
  typedef logic [DataWidth/8-1:0] vreg_be_t;
  typedef logic [StarveCntWidth-1:0] starve_cnt_t;

endpackage

// File: rtl/spatz_vrf_prio_arb.sv
// Combinational fixed-priority arbiter: promoted requests first, then lowest index.
module spatz_vrf_prio_arb #(
  parameter int unsigned NumReq = 4
) (
  input  logic [NumReq-1:0] req,
  input  logic [NumReq-1:0] promote,
  output logic [NumReq-1:0] gnt
);

  logic [NumReq-1:0] req_hi;
  logic [NumReq-1:0] cand;
  logic              found;

  always_comb begin
    req_hi = req & promote;
    cand   = (|req_hi) ? req_hi : req;
    gnt    = '0;
    found  = 1'b0;
    for (int unsigned i = 0; i < NumReq; i++) begin
      if (cand[i] && !found) begin
        gnt[i] = 1'b1;
        found  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/spatz_vrf_arbiter.sv
// Spatz VRF bank arbiter: routes read/write requesters onto banked VRF ports.
// Define SPATZ_VRF_STARVE_EN to enable starvation counters and promotion.
module spatz_vrf_arbiter
  import spatz_pkg::*;
#(
  parameter int unsigned NrReadPorts                = 5,
  parameter int unsigned NrWritePorts               = 3,
  parameter int unsigned NrBanks                    = 4,
  parameter int unsigned NrBankRdPorts              = 3,
  parameter int unsigned RdPortMap [NrReadPorts]    = '{0, 1, 2, 1, 2},
  parameter int unsigned StarveLimit                = DefaultStarveLimit
) (
  input  logic                                           clk_i,
  input  logic                                           rst_i,
  input  vreg_addr_t [NrWritePorts-1:0]                  waddr_i,
  input  vreg_data_t [NrWritePorts-1:0]                  wdata_i,
  input  logic       [NrWritePorts-1:0]                  we_i,
  input  vreg_be_t   [NrWritePorts-1:0]                  wbe_i,
  output logic       [NrWritePorts-1:0]                  wgnt_o,
  input  vreg_addr_t [NrReadPorts-1:0]                   raddr_i,
  input  logic       [NrReadPorts-1:0]                   re_i,
  output logic       [NrReadPorts-1:0]                   rgnt_o,
  output vreg_data_t [NrReadPorts-1:0]                   rdata_o,
  output logic       [NrReadPorts-1:0]                   rvalid_o,
  output vreg_idx_t  [NrBanks-1:0]                       bank_waddr_o,
  output vreg_data_t [NrBanks-1:0]                       bank_wdata_o,
  output logic       [NrBanks-1:0]                       bank_we_o,
  output vreg_be_t   [NrBanks-1:0]                       bank_wbe_o,
  output vreg_idx_t  [NrBanks-1:0][NrBankRdPorts-1:0]    bank_raddr_o,
  output logic       [NrBanks-1:0][NrBankRdPorts-1:0]    bank_re_o,
  input  vreg_data_t [NrBanks-1:0][NrBankRdPorts-1:0]    bank_rdata_i
);

  localparam int unsigned BankSelW = (NrBanks > 1) ? $clog2(NrBanks) : 1;
  localparam int unsigned PortW    = (NrBankRdPorts > 1) ? $clog2(NrBankRdPorts) : 1;

  if ((NrBanks == 0) || ((NrBanks & (NrBanks - 1)) != 0)) begin : g_bad_banks
    $error("spatz_vrf_arbiter: NrBanks must be a power of two");
  end
  if (NrBanks > (1 << BankWidth)) begin : g_bad_bank_field
    $error("spatz_vrf_arbiter: NrBanks exceeds the vreg_addr_t bank field");
  end
  if ((StarveLimit < 1) || (StarveLimit > 15)) begin : g_bad_starve
    $error("spatz_vrf_arbiter: StarveLimit must be in 1..15");
  end
  for (genvar r = 0; r < NrReadPorts; r++) begin : g_chk_map
    if (RdPortMap[r] >= NrBankRdPorts) begin : g_bad_map
      $error("spatz_vrf_arbiter: RdPortMap entry out of range");
    end
  end

  logic [NrBanks-1:0][NrWritePorts-1:0]                   wreq;
  logic [NrBanks-1:0][NrWritePorts-1:0]                   wgnt_bank;
  logic [NrBanks-1:0][NrBankRdPorts-1:0][NrReadPorts-1:0] rreq;
  logic [NrBanks-1:0][NrBankRdPorts-1:0][NrReadPorts-1:0] rgnt_port;
  logic [NrWritePorts-1:0]                                wpromote;
  logic [NrReadPorts-1:0]                                 rpromote;

  logic [NrReadPorts-1:0][BankSelW-1:0] rbank_d, rbank_q;
  logic [NrReadPorts-1:0][PortW-1:0]    rport_d, rport_q;
  logic [NrReadPorts-1:0]               rvalid_q;
  logic                                 run_q;

  always_comb begin
    wreq = '0;
    rreq = '0;
    for (int unsigned b = 0; b < NrBanks; b++) begin
      for (int unsigned w = 0; w < NrWritePorts; w++) begin
        wreq[b][w] = we_i[w] && (waddr_i[w].bank == BankWidth'(b));
      end
      for (int unsigned p = 0; p < NrBankRdPorts; p++) begin
        for (int unsigned r = 0; r < NrReadPorts; r++) begin
          rreq[b][p][r] = re_i[r] && (raddr_i[r].bank == BankWidth'(b)) && (RdPortMap[r] == p);
        end
      end
    end
  end

  for (genvar b = 0; b < NrBanks; b++) begin : g_bank
    spatz_vrf_prio_arb #(.NumReq(NrWritePorts)) i_warb (
      .req     (wreq[b]),
      .promote (wpromote),
      .gnt     (wgnt_bank[b])
    );
    for (genvar p = 0; p < NrBankRdPorts; p++) begin : g_port
      spatz_vrf_prio_arb #(.NumReq(NrReadPorts)) i_rarb (
        .req     (rreq[b][p]),
        .promote (rpromote),
        .gnt     (rgnt_port[b][p])
      );
    end
  end

  always_comb begin
    wgnt_o       = '0;
    bank_we_o    = '0;
    bank_waddr_o = '0;
    bank_wdata_o = '0;
    bank_wbe_o   = '0;
    for (int unsigned b = 0; b < NrBanks; b++) begin
      for (int unsigned w = 0; w < NrWritePorts; w++) begin
        if (wgnt_bank[b][w]) begin
          wgnt_o[w]       = 1'b1;
          bank_we_o[b]    = 1'b1;
          bank_waddr_o[b] = waddr_i[w].vreg;
          bank_wdata_o[b] = wdata_i[w];
          bank_wbe_o[b]   = wbe_i[w];
        end
      end
    end
  end

  always_comb begin
    rgnt_o       = '0;
    bank_re_o    = '0;
    bank_raddr_o = '0;
    rbank_d      = '0;
    rport_d      = '0;
    for (int unsigned b = 0; b < NrBanks; b++) begin
      for (int unsigned p = 0; p < NrBankRdPorts; p++) begin
        for (int unsigned r = 0; r < NrReadPorts; r++) begin
          if (rgnt_port[b][p][r]) begin
            rgnt_o[r]          = 1'b1;
            bank_re_o[b][p]    = 1'b1;
            bank_raddr_o[b][p] = raddr_i[r].vreg;
            rbank_d[r]         = BankSelW'(b);
            rport_d[r]         = PortW'(p);
          end
        end
      end
    end
  end

  // run_q masks grants seen around reset release so rvalid never fires in the
  // first cycle after rst_i drops.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      run_q    <= 1'b0;
      rvalid_q <= '0;
      rbank_q  <= '0;
      rport_q  <= '0;
    end else begin
      run_q    <= 1'b1;
      rvalid_q <= rgnt_o & {NrReadPorts{run_q}};
      rbank_q  <= rbank_d;
      rport_q  <= rport_d;
    end
  end

  always_comb begin
    rdata_o = '0;
    for (int unsigned r = 0; r < NrReadPorts; r++) begin
      if (rvalid_q[r]) rdata_o[r] = bank_rdata_i[rbank_q[r]][rport_q[r]];
    end
  end

  assign rvalid_o = rvalid_q;

`ifdef SPATZ_VRF_STARVE_EN
  starve_cnt_t [NrWritePorts-1:0] wcnt_q;
  starve_cnt_t [NrReadPorts-1:0]  rcnt_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wcnt_q <= '0;
      rcnt_q <= '0;
    end else begin
      for (int unsigned w = 0; w < NrWritePorts; w++) begin
        if (!we_i[w] || wgnt_o[w])                           wcnt_q[w] <= '0;
        else if (wcnt_q[w] != starve_cnt_t'(StarveLimit))    wcnt_q[w] <= wcnt_q[w] + 1'b1;
      end
      for (int unsigned r = 0; r < NrReadPorts; r++) begin
        if (!re_i[r] || rgnt_o[r])                           rcnt_q[r] <= '0;
        else if (rcnt_q[r] != starve_cnt_t'(StarveLimit))    rcnt_q[r] <= rcnt_q[r] + 1'b1;
      end
    end
  end

  always_comb begin
    wpromote = '0;
    rpromote = '0;
    for (int unsigned w = 0; w < NrWritePorts; w++) begin
      wpromote[w] = (wcnt_q[w] == starve_cnt_t'(StarveLimit));
    end
    for (int unsigned r = 0; r < NrReadPorts; r++) begin
      rpromote[r] = (rcnt_q[r] == starve_cnt_t'(StarveLimit));
    end
  end
`else
  always_comb begin
    wpromote = '0;
    rpromote = '0;
  end
`endif

endmodule

// File: tb/tb_spatz_vrf_arbiter.sv
// Directed self-checking bench for spatz_vrf_arbiter (default 5R/3W/4-bank configuration).
module tb_spatz_vrf_arbiter;
  import spatz_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;

  vreg_addr_t [2:0]      waddr;
  vreg_data_t [2:0]      wdata;
  logic       [2:0]      we;
  vreg_be_t   [2:0]      wbe;
  logic       [2:0]      wgnt;
  vreg_addr_t [4:0]      raddr;
  logic       [4:0]      re;
  logic       [4:0]      rgnt;
  vreg_data_t [4:0]      rdata;
  logic       [4:0]      rvalid;
  vreg_idx_t  [3:0]      bank_waddr;
  vreg_data_t [3:0]      bank_wdata;
  logic       [3:0]      bank_we;
  vreg_be_t   [3:0]      bank_wbe;
  vreg_idx_t  [3:0][2:0] bank_raddr;
  logic       [3:0][2:0] bank_re;
  vreg_data_t [3:0][2:0] bank_rdata;

  int checks   = 0;
  int failures = 0;

  spatz_vrf_arbiter #(
    .NrReadPorts   (5),
    .NrWritePorts  (3),
    .NrBanks       (4),
    .NrBankRdPorts (3),
    .StarveLimit   (4)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .waddr_i      (waddr),
    .wdata_i      (wdata),
    .we_i         (we),
    .wbe_i        (wbe),
    .wgnt_o       (wgnt),
    .raddr_i      (raddr),
    .re_i         (re),
    .rgnt_o       (rgnt),
    .rdata_o      (rdata),
    .rvalid_o     (rvalid),
    .bank_waddr_o (bank_waddr),
    .bank_wdata_o (bank_wdata),
    .bank_we_o    (bank_we),
    .bank_wbe_o   (bank_wbe),
    .bank_raddr_o (bank_raddr),
    .bank_re_o    (bank_re),
    .bank_rdata_i (bank_rdata)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic vreg_addr_t mk_addr(input int bank, input int vreg);
    vreg_addr_t a;
    a.bank = BankWidth'(bank);
    a.vreg = VregWidth'(vreg);
    return a;
  endfunction

  function automatic logic [31:0] exp_rdata(input int bank, input int port);
    return 32'hB000_0000 | (32'(bank) << 8) | 32'(port);
  endfunction

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  int first_r3;
  int r3_grants;
  int ngnt;
  int nval;

  initial begin
    waddr = '0; wdata = '0; we = '0; wbe = '0;
    raddr = '0; re = '0;
    for (int b = 0; b < 4; b++)
      for (int p = 0; p < 3; p++)
        bank_rdata[b][p] = exp_rdata(b, p);

    #1;
    check_eq("reset_rvalid", rvalid, 0);
    check_eq("reset_rdata", rdata, 0);
    check_eq("reset_rgnt_idle", rgnt, 0);
    next_cycle();
    next_cycle();
    rst = 1'b0;
    next_cycle();
    next_cycle();

    // Read conflict: requesters 1 and 3 both on bank 2, port 1
    raddr[1] = mk_addr(2, 3);
    raddr[3] = mk_addr(2, 5);
    re = 5'b01010;
    #1;
    check_eq("rd_conf_rgnt", rgnt, 5'b00010);
    check_eq("rd_conf_bank_re", bank_re, 12'h080);
    check_eq("rd_conf_bank_raddr", bank_raddr[2][1], 3);
    next_cycle();
    check_eq("rd_conf_rvalid", rvalid, 5'b00010);
    check_eq("rd_conf_rdata1", rdata[1], exp_rdata(2, 1));
    check_eq("rd_conf_rdata3", rdata[3], 0);
    re = 5'b01000;
    #1;
    check_eq("rd_conf_rgnt_r3", rgnt, 5'b01000);
    next_cycle();
    check_eq("rd_conf_rvalid_r3", rvalid, 5'b01000);
    check_eq("rd_conf_rdata_r3", rdata[3], exp_rdata(2, 1));
    re = '0;

    // Write conflict plus a same-cycle read of the written vreg
    waddr[0] = mk_addr(0, 1); wdata[0] = 32'h1111_0000; wbe[0] = 4'hF;
    waddr[1] = mk_addr(3, 4); wdata[1] = 32'h2222_0000; wbe[1] = 4'h3;
    waddr[2] = mk_addr(0, 2); wdata[2] = 32'h3333_0000; wbe[2] = 4'hC;
    we = 3'b111;
    raddr[0] = mk_addr(0, 1);
    re = 5'b00001;
    #1;
    check_eq("wr_conf_wgnt", wgnt, 3'b011);
    check_eq("wr_conf_bank_we", bank_we, 4'b1001);
    check_eq("wr_conf_wdata0", bank_wdata[0], 32'h1111_0000);
    check_eq("wr_conf_wdata3", bank_wdata[3], 32'h2222_0000);
    check_eq("wr_conf_waddr3", bank_waddr[3], 4);
    check_eq("wr_conf_wbe0", bank_wbe[0], 4'hF);
    check_eq("wr_conf_idle_wdata1", bank_wdata[1], 0);
    check_eq("wr_conf_idle_wbe2", bank_wbe[2], 0);
    next_cycle();
    check_eq("wr_rd_no_fwd", rdata[0], exp_rdata(0, 0));
    we = '0;
    re = '0;
    next_cycle();
    next_cycle();

    // Starvation: requesters 1 and 3 continuously on bank 0, port 1
    raddr[1] = mk_addr(0, 1);
    raddr[3] = mk_addr(0, 3);
    first_r3 = 0;
    r3_grants = 0;
    for (int c = 1; c <= 20; c++) begin
      re = 5'b01010;
      #1;
      if (rgnt[3]) begin
        r3_grants++;
        if (first_r3 == 0) first_r3 = c;
      end
`ifdef SPATZ_VRF_STARVE_EN
      if (c == 6) check_eq("starve_after_clear", rgnt, 5'b00010);
`endif
      next_cycle();
    end
`ifdef SPATZ_VRF_STARVE_EN
    check_eq("starve_first_r3", first_r3, 5);
`else
    check_eq("nostarve_r3_grants", r3_grants, 0);
`endif
    re = '0;
    next_cycle();
    next_cycle();

    // Reset in the cycle after a read grant
    raddr[0] = mk_addr(1, 2);
    re = 5'b00001;
    #1;
    check_eq("rst_mid_rgnt", rgnt, 5'b00001);
    next_cycle();
    check_eq("rst_mid_rvalid_pre", rvalid, 5'b00001);
    rst = 1'b1;
    #1;
    check_eq("rst_mid_rvalid", rvalid, 0);
    check_eq("rst_mid_rdata", rdata, 0);
    check_eq("rst_mid_rgnt_comb", rgnt, 5'b00001);
    next_cycle();
    next_cycle();
    rst = 1'b0;
    next_cycle();
    check_eq("rst_release_rvalid", rvalid, 0);
    re = '0;
    next_cycle();
    check_eq("rst_release_rvalid2", rvalid, 0);

    // Streaming: requester 0, 8 back-to-back reads
    ngnt = 0;
    nval = 0;
    for (int i = 0; i < 8; i++) begin
      raddr[0] = mk_addr(i % 4, i);
      re = 5'b00001;
      #1;
      if (rgnt[0]) ngnt++;
      next_cycle();
      if (rvalid[0]) nval++;
      check_eq("stream_rdata", rdata[0], exp_rdata(i % 4, 0));
    end
    re = '0;
    next_cycle();
    check_eq("stream_tail_rvalid", rvalid, 0);
    check_eq("stream_gnt_count", ngnt, 8);
    check_eq("stream_rvalid_count", nval, 8);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
